unit_propagate: RTL and testbench
=================================

# unit_propagate

Consumer of the unit-clause finder's result in the DPLL datapath. Given a formula and a literal that has just been assigned true, `unit_propagate` rewrites the formula, one clause per cycle:
- clauses satisfied by the literal are dropped;
- occurrences of the negated literal are deleted from the remaining clauses;
- conflict (empty clause) and satisfiability (empty formula) are reported.

It uses the same start/ended handshake as the finder, so the controller can chain find → propagate → find.

## Interface

Parameters:
- `NUMBER_CLAUSES`, 16, clause slots in a formula.
- `NUMBER_LITS`, 4, literal slots per clause.
- `VAR_BITS`, 5, width of a variable index.

Data layout (`common` package types, all packed):
- `lit` = {neg (1 bit), var (`VAR_BITS`)}.
- `clause` = {len (`$clog2(NUMBER_LITS+1)`), lits[0..NUMBER_LITS-1]}.
- `formula` = {len (`$clog2(NUMBER_CLAUSES+1)`), clauses[0..NUMBER_CLAUSES-1]}.

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low; sampled on the rising edge of `clock`.
- `start` in 1: request; honoured only in IDLE.
- `in_formula` in formula: formula to simplify; sampled with `start`.
- `in_lit` in lit: literal assigned true; sampled with `start`.
- `ended` out 1: one-cycle completion pulse.
- `conflict` out 1: the result contains an empty clause; valid when `ended`=1, held until the next accepted `start`.
- `empty` out 1: result formula len = 0 (satisfied); same validity as `conflict`.
- `out_formula` out formula: simplified formula; valid when `ended`=1, held until the next accepted `start`.

## Operation

- States: IDLE, SCAN.
- **IDLE**: `start`=1 latches `in_formula` and `in_lit`, sets clause index i=0 and write index w=0, clears `out_formula`/`conflict`/`empty`, and moves to SCAN. `start`=0 does nothing.
- **SCAN**, one edge per clause i, where C = latched clauses[i]:
  - **Termination**: if i ≥ formula.len or i = `NUMBER_CLAUSES`, then `ended`<=1, `empty`<=(w==0), `out_formula.len`<=w, and the state returns to IDLE.
  - **Literal matching** is full equality on {neg, var}, checked only in slots 0..C.len-1. Slots at or above C.len are ignored.
  - **Satisfied**: if any slot equals `in_lit`, the clause is dropped. w is unchanged. Satisfied takes priority even if the clause also contains ¬`in_lit`.
  - **Reduced**: otherwise, every slot equal to {~in_lit.neg, in_lit.var} is removed. Survivors are compacted to the low slots in original order, vacated slots are zero, and new len = survivor count. The result is written to out_formula.clauses[w] and w increments.
  - **Conflict**: if the reduced len = 0, `conflict`<=1, `ended`<=1, `out_formula.len`<=w+1, `empty`<=0, and the state returns to IDLE on this same edge. No further clauses are processed.
  - i increments on every non-terminating edge.
- Untouched clause slots at index ≥ w stay zero.
- A `start` received during SCAN is ignored and not queued.
- An input clause with len=0 is treated as a conflict at that clause.

## Timing

- **Reset**: `reset`=0 at an edge forces IDLE; `ended`, `conflict`, `empty`, `out_formula`, i, w all go to 0. Reset mid-SCAN aborts the scan with no `ended` pulse.
- **Latency**: with `start` accepted at edge 0 and formula len L, clause k is processed at edge k+1.
  - No conflict: `ended` is high for the cycle after edge L+1.
  - Conflict at clause j: `ended` is high after edge j+1.
  - L = 0: `ended` after edge 1 with `empty`=1.
- `ended` is high for exactly one cycle. A new `start` may be asserted in that same cycle; the block is in IDLE then, so it is accepted.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

1. **Satisfied clause removed**: formula {(x1), (¬x1∨x2), (x3∨x4)}, `in_lit`=x1 → `ended` after edge 4; out len=2, clauses (x2),(x3∨x4); `conflict`=0, `empty`=0.
2. **All satisfied**: formula {(x2∨x5), (x2)}, `in_lit`=x2 → out len=0, `empty`=1, `ended` after edge 3.
3. **Conflict early exit**: formula {(x3∨x4), (¬x1), (x5)}, `in_lit`=x1 → `conflict`=1, `ended` after edge 2, out len=2, clauses[1].len=0, clauses[2] zero.
4. **Duplicates and priority**: clause (¬x7∨x2∨¬x7) with `in_lit`=x7 → out clause (x2), len=1. Clause (x7∨¬x7) → dropped.
5. **Handshake robustness**: `start` held high for the whole scan produces exactly one `ended`. A new `start` with different data in the `ended` cycle is accepted and produces a second, correct result.
6. **Reset mid-scan**: `reset`=0 at edge 2 of a 6-clause scan → all outputs 0, no `ended`. The next `start` processes correctly from scratch.

Source files
------------

// File: rtl/unit_propagate.sv
// unit_propagate: rewrites a CNF formula after one literal is made true (drop satisfied, strip negated).
// Latency: one clause per cycle; ended pulses L+1 edges after start (j+1 on a conflict at clause j).
// Backpressure: none; start is only honoured in IDLE, starts during a scan are dropped.

package common;
  localparam int PKG_NUMBER_CLAUSES = 16;
  localparam int PKG_NUMBER_LITS    = 4;
  localparam int PKG_VAR_BITS       = 5;
  localparam int PKG_CLEN_W         = $clog2(PKG_NUMBER_LITS + 1);
  localparam int PKG_FLEN_W         = $clog2(PKG_NUMBER_CLAUSES + 1);

  // Literal: polarity bit above the variable index.
  typedef struct packed {
    logic                    neg;
    logic [PKG_VAR_BITS-1:0] var_idx;
  } lit;

  typedef struct packed {
    logic [PKG_CLEN_W-1:0]     len;
    lit [0:PKG_NUMBER_LITS-1]  lits;
  } clause;

  typedef struct packed {
    logic [PKG_FLEN_W-1:0]          len;
    clause [0:PKG_NUMBER_CLAUSES-1] clauses;
  } formula;
endpackage

module unit_propagate
  import common::*;
#(
  // Port types come from the common package, so these must match its constants.
  parameter int NUMBER_CLAUSES = PKG_NUMBER_CLAUSES,
  parameter int NUMBER_LITS    = PKG_NUMBER_LITS,
  parameter int VAR_BITS       = PKG_VAR_BITS
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   start,
  input  formula in_formula,
  input  lit     in_lit,
  output logic   ended,
  output logic   conflict,
  output logic   empty,
  output formula out_formula
);

  localparam int CLEN_W    = $clog2(NUMBER_LITS + 1);
  localparam int FLEN_W    = $clog2(NUMBER_CLAUSES + 1);
  localparam int IDX_W     = $clog2(NUMBER_CLAUSES);
  localparam int LIT_IDX_W = $clog2(NUMBER_LITS);

  // Catch a parameter override that would disagree with the packed port types.
  if (NUMBER_CLAUSES != PKG_NUMBER_CLAUSES || NUMBER_LITS != PKG_NUMBER_LITS ||
      VAR_BITS != PKG_VAR_BITS) begin : g_param_check
    $error("unit_propagate parameters must match the common package");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t             state_q, state_d;
  formula             fin_q, fin_d;
  lit                 lit_q, lit_d;
  logic [FLEN_W-1:0]  i_q, i_d;
  logic [FLEN_W-1:0]  w_q, w_d;
  formula             out_q, out_d;
  logic               ended_q, ended_d;
  logic               conflict_q, conflict_d;
  logic               empty_q, empty_d;

  // Per-clause evaluation of the current clause i
  logic [IDX_W-1:0]   cur_idx;
  logic [IDX_W-1:0]   w_idx;
  clause              cur_cl;
  clause              red_cl;
  logic [CLEN_W-1:0]  red_len;
  logic               cur_sat;
  lit                 neg_lit;
  logic               scan_done;
  logic               red_empty;

  // Match slots below len against the literal and compact the survivors of its negation.
  always_comb begin
    cur_idx  = i_q[IDX_W-1:0];
    w_idx    = w_q[IDX_W-1:0];
    cur_cl   = fin_q.clauses[cur_idx];
    neg_lit  = lit_q;
    neg_lit.neg = ~lit_q.neg;
    cur_sat  = 1'b0;
    red_cl   = '0;
    red_len  = '0;
    for (int k = 0; k < NUMBER_LITS; k++) begin
      if (k < int'(cur_cl.len)) begin
        if (cur_cl.lits[k] == lit_q) begin
          cur_sat = 1'b1;
        end
        if (cur_cl.lits[k] != neg_lit) begin
          red_cl.lits[red_len[LIT_IDX_W-1:0]] = cur_cl.lits[k];
          red_len = red_len + 1'b1;
        end
      end
    end
    red_cl.len = red_len;
    red_empty  = (red_len == '0);
    // Index cap guards against a len field larger than the slot count.
    scan_done  = (i_q >= fin_q.len) || (i_q == FLEN_W'(NUMBER_CLAUSES));
  end

  // State register and all datapath flops, synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      fin_q      <= '0;
      lit_q      <= '0;
      i_q        <= '0;
      w_q        <= '0;
      out_q      <= '0;
      ended_q    <= 1'b0;
      conflict_q <= 1'b0;
      empty_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fin_q      <= fin_d;
      lit_q      <= lit_d;
      i_q        <= i_d;
      w_q        <= w_d;
      out_q      <= out_d;
      ended_q    <= ended_d;
      conflict_q <= conflict_d;
      empty_q    <= empty_d;
    end
  end

  // Next state: leave IDLE on start, return when the scan runs out of clauses or hits a conflict.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (scan_done || (!cur_sat && red_empty)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and outputs: latch on start, then drop, rewrite or terminate one clause per edge.
  always_comb begin
    fin_d      = fin_q;
    lit_d      = lit_q;
    i_d        = i_q;
    w_d        = w_q;
    out_d      = out_q;
    ended_d    = 1'b0;
    conflict_d = conflict_q;
    empty_d    = empty_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          fin_d      = in_formula;
          lit_d      = in_lit;
          i_d        = '0;
          w_d        = '0;
          out_d      = '0;
          conflict_d = 1'b0;
          empty_d    = 1'b0;
        end
      end
      SCAN: begin
        if (scan_done) begin
          ended_d   = 1'b1;
          empty_d   = (w_q == '0);
          out_d.len = w_q;
        end else if (cur_sat) begin
          // Satisfied clause vanishes; output slot stays free for the next survivor.
          i_d = i_q + 1'b1;
        end else begin
          out_d.clauses[w_idx] = red_cl;
          if (red_empty) begin
            // Empty clause: report it as the last clause of the result and stop.
            conflict_d = 1'b1;
            ended_d    = 1'b1;
            empty_d    = 1'b0;
            out_d.len  = w_q + 1'b1;
          end else begin
            w_d = w_q + 1'b1;
            i_d = i_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign ended       = ended_q;
  assign conflict    = conflict_q;
  assign empty       = empty_q;
  assign out_formula = out_q;

endmodule

// File: tb/tb_unit_propagate.sv
// Directed scoreboard bench for unit_propagate: expectations are queued at issue time
// and a negedge monitor pops one per ended pulse, checking timing and result.
module tb_unit_propagate;
  import common::*;

  logic   clock;
  logic   reset;
  logic   start;
  formula in_formula;
  lit     in_lit;
  logic   ended;
  logic   conflict;
  logic   empty;
  formula out_formula;

  unit_propagate dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .in_formula  (in_formula),
    .in_lit      (in_lit),
    .ended       (ended),
    .conflict    (conflict),
    .empty       (empty),
    .out_formula (out_formula)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int edge_cnt = 0;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string  name;
    int     edge_no;
    logic   conflict;
    logic   empty;
    formula f;
  } exp_t;

  exp_t sb[$];

  localparam lit Z = '0;

  function automatic lit P(int v);
    lit r;
    r.neg     = 1'b0;
    r.var_idx = PKG_VAR_BITS'(v);
    return r;
  endfunction

  function automatic lit N(int v);
    lit r;
    r.neg     = 1'b1;
    r.var_idx = PKG_VAR_BITS'(v);
    return r;
  endfunction

  function automatic clause cl(int n, lit a, lit b, lit c, lit d);
    clause r;
    r.len     = PKG_CLEN_W'(n);
    r.lits[0] = a;
    r.lits[1] = b;
    r.lits[2] = c;
    r.lits[3] = d;
    return r;
  endfunction

  task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: every ended pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (ended) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_ended: got ended=1 at edge %0d want no pulse", edge_cnt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_edge"},     edge_cnt,    e.edge_no);
        chk({e.name, "_conflict"}, conflict,    e.conflict);
        chk({e.name, "_empty"},    empty,       e.empty);
        chk({e.name, "_formula"},  out_formula, e.f);
      end
    end
  end

  // Called at a negedge just before start is raised; lat counts edges from the accepting edge.
  task automatic push_exp(string nm, int lat, logic cf, logic em, formula fe);
    exp_t e;
    e.name     = nm;
    e.edge_no  = edge_cnt + 1 + lat;
    e.conflict = cf;
    e.empty    = em;
    e.f        = fe;
    sb.push_back(e);
  endtask

  task automatic wait_ended(string nm);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (ended) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no ended within 60 cycles want one pulse", nm);
    end
  endtask

  task automatic run(string nm, formula f, lit l, int lat, logic cf, logic em, formula fe);
    push_exp(nm, lat, cf, em, fe);
    start      = 1'b1;
    in_formula = f;
    in_lit     = l;
    @(negedge clock);
    start = 1'b0;
    wait_ended(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running want completion");
    $fatal(1);
  end

  formula f1, e1, f2, e2, fa, ea;

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    in_formula = '0;
    in_lit     = '0;
    repeat (3) @(negedge clock);
    chk("rst_ended",    ended,       1'b0);
    chk("rst_conflict", conflict,    1'b0);
    chk("rst_empty",    empty,       1'b0);
    chk("rst_formula",  out_formula, '0);
    reset = 1'b1;
    @(negedge clock);

    // Satisfied clause dropped, negated literal stripped
    f1 = '0; f1.len = 3;
    f1.clauses[0] = cl(1, P(1), Z, Z, Z);
    f1.clauses[1] = cl(2, N(1), P(2), Z, Z);
    f1.clauses[2] = cl(2, P(3), P(4), Z, Z);
    e1 = '0; e1.len = 2;
    e1.clauses[0] = cl(1, P(2), Z, Z, Z);
    e1.clauses[1] = cl(2, P(3), P(4), Z, Z);
    run("sat_drop", f1, P(1), 4, 1'b0, 1'b0, e1);

    // Everything satisfied
    f2 = '0; f2.len = 2;
    f2.clauses[0] = cl(2, P(2), P(5), Z, Z);
    f2.clauses[1] = cl(1, P(2), Z, Z, Z);
    e2 = '0;
    run("all_sat", f2, P(2), 3, 1'b0, 1'b1, e2);

    // Conflict stops the scan early
    fa = '0; fa.len = 3;
    fa.clauses[0] = cl(2, P(3), P(4), Z, Z);
    fa.clauses[1] = cl(1, N(1), Z, Z, Z);
    fa.clauses[2] = cl(1, P(5), Z, Z, Z);
    ea = '0; ea.len = 2;
    ea.clauses[0] = cl(2, P(3), P(4), Z, Z);
    run("conflict", fa, P(1), 2, 1'b1, 1'b0, ea);

    // Duplicates, satisfied priority, slots above len ignored, garbage slots cleared
    fa = '0; fa.len = 4;
    fa.clauses[0] = cl(3, N(7), P(2), N(7), Z);
    fa.clauses[1] = cl(2, P(7), N(7), Z, Z);
    fa.clauses[2] = cl(1, P(3), P(7), Z, Z);
    fa.clauses[3] = cl(1, P(4), Z, N(7), P(9));
    ea = '0; ea.len = 3;
    ea.clauses[0] = cl(1, P(2), Z, Z, Z);
    ea.clauses[1] = cl(1, P(3), Z, Z, Z);
    ea.clauses[2] = cl(1, P(4), Z, Z, Z);
    run("dup_prio", fa, P(7), 5, 1'b0, 1'b0, ea);

    // Negative literal assigned true
    fa = '0; fa.len = 2;
    fa.clauses[0] = cl(2, P(3), P(4), Z, Z);
    fa.clauses[1] = cl(2, N(3), P(1), Z, Z);
    ea = '0; ea.len = 1;
    ea.clauses[0] = cl(1, P(4), Z, Z, Z);
    run("neg_lit", fa, N(3), 3, 1'b0, 1'b0, ea);

    // Empty formula: contents beyond len must not be looked at
    fa = '0;
    fa.clauses[0] = cl(0, Z, Z, Z, Z);
    fa.clauses[1] = cl(1, N(1), Z, Z, Z);
    ea = '0;
    run("len0", fa, P(1), 1, 1'b0, 1'b1, ea);

    // Input clause of length zero is a conflict
    fa = '0; fa.len = 2;
    fa.clauses[0] = cl(1, P(3), Z, Z, Z);
    fa.clauses[1] = cl(0, Z, Z, Z, Z);
    ea = '0; ea.len = 2;
    ea.clauses[0] = cl(1, P(3), Z, Z, Z);
    run("clause_len0", fa, P(1), 2, 1'b1, 1'b0, ea);

    // Full formula of 16 clauses, then an oversized len capped at 16 slots
    fa = '0; fa.len = 16;
    for (int k = 0; k < 16; k++) fa.clauses[k] = cl(1, P(2), Z, Z, Z);
    ea = fa;
    run("full16", fa, P(3), 17, 1'b0, 1'b0, ea);
    fa.len = 31;
    run("len_cap", fa, P(3), 17, 1'b0, 1'b0, ea);

    // Start held through the scan, then new data taken in the ended cycle
    push_exp("held_a", 4, 1'b0, 1'b0, e1);
    start      = 1'b1;
    in_formula = f1;
    in_lit     = P(1);
    @(negedge clock);
    wait_ended("held_a");
    push_exp("held_b", 3, 1'b0, 1'b1, e2);
    in_formula = f2;
    in_lit     = P(2);
    @(negedge clock);
    start = 1'b0;
    wait_ended("held_b");
    @(negedge clock);

    // Reset at edge 2 of a six-clause scan aborts silently
    fa = '0; fa.len = 6;
    for (int k = 0; k < 6; k++) fa.clauses[k] = cl(1, P(2), Z, Z, Z);
    start      = 1'b1;
    in_formula = fa;
    in_lit     = P(3);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_ended",    ended,       1'b0);
    chk("midrst_conflict", conflict,    1'b0);
    chk("midrst_empty",    empty,       1'b0);
    chk("midrst_formula",  out_formula, '0);
    reset = 1'b1;
    repeat (8) @(negedge clock);
    run("after_rst", f1, P(1), 4, 1'b0, 1'b0, e1);

    repeat (5) @(negedge clock);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
